// File: rtl/i2c_target_rx.sv
// ---------------------------------------------------------------------------
// i2c_target_rx
//   Write-only I2C target receiver. SCL/SDA are oversampled on Clock,
//   START/STOP conditions are detected, and a 7-bit address is matched. The
//   block ACKs a matching write address and every accepted data byte by
//   pulling SDA low (open-drain). Each accepted byte is delivered on
//   Data/DataValid. Read requests, foreign addresses and bytes the sink
//   cannot take (Ready = 0) are NACKed by leaving SDA released.
//
// Optional feature (macro I2C_GLITCH_FILTER_EN):
//   When defined, each synchronized line passes through a filter. A new level
//   is accepted only after FILT_CYCLES consecutive equal samples. Shorter
//   pulses are discarded, and every edge gains FILT_CYCLES cycles of latency.
//   When undefined, an edge becomes visible 3 Clock cycles after the pin
//   changes.
//
// Ports
//   Clock      in   system clock, at least 8x the SCL rate
//   Reset_n    in   synchronous active-low reset
//   SCL_in     in   bus SCL level (asynchronous)
//   SDA_in     in   bus SDA level (asynchronous)
//   SDA_oe     out  1 = pull SDA low, 0 = release
//   Ready      in   sink can accept a byte; sampled at the 8th data bit
//   Data       out  last accepted data byte, MSB received first
//   DataValid  out  one-cycle strobe marking a new Data value
//   Busy       out  high from a matched address ACK until STOP/START
//   state_dbg  out  current FSM state encoding (debug visibility)
//
// Handshake: Data/DataValid is a push-only strobe with no back-pressure on
// the strobe itself. Ready is sampled only on the 8th SCL rise of a data
// byte. If Ready is low then, the byte is NACKed and never presented.
// ---------------------------------------------------------------------------
module i2c_target_rx #(
  parameter logic [6:0] ADDR        = 7'h42,
  parameter int         FILT_CYCLES = 3
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       SCL_in,
  input  logic       SDA_in,
  output logic       SDA_oe,
  input  logic       Ready,
  output logic [7:0] Data,
  output logic       DataValid,
  output logic       Busy,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_DATA     = 3'd3,
    ST_DATA_ACK = 3'd4,
    ST_IGNORE   = 3'd5
  } state_t;

  if (FILT_CYCLES < 1 || FILT_CYCLES > 15) begin : g_filt_range
    $error("FILT_CYCLES must be within 1..15");
  end

  // -------------------------------------------------------------------------
  // Two-flop synchronizers. They reset to 1 so the bus looks idle.
  // -------------------------------------------------------------------------
  logic scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
    end else begin
      scl_s1_q <= SCL_in;
      scl_s2_q <= scl_s1_q;
      sda_s1_q <= SDA_in;
      sda_s2_q <= sda_s1_q;
    end
  end

  logic scl_lvl, sda_lvl;

`ifdef I2C_GLITCH_FILTER_EN
  // A counter tracks how long the synchronized sample has disagreed with the
  // accepted level. The new level is taken on the FILT_CYCLES-th
  // consecutive disagreeing sample.
  localparam logic [3:0] FILT_LAST = 4'(FILT_CYCLES - 1);

  logic       scl_f_q, scl_f_d, sda_f_q, sda_f_d;
  logic [3:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;

  always_comb begin
    scl_f_d   = scl_f_q;
    scl_cnt_d = 4'd0;
    if (scl_s2_q != scl_f_q) begin
      if (scl_cnt_q == FILT_LAST) scl_f_d   = scl_s2_q;
      else                        scl_cnt_d = scl_cnt_q + 4'd1;
    end
    sda_f_d   = sda_f_q;
    sda_cnt_d = 4'd0;
    if (sda_s2_q != sda_f_q) begin
      if (sda_cnt_q == FILT_LAST) sda_f_d   = sda_s2_q;
      else                        sda_cnt_d = sda_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      scl_f_q   <= 1'b1;
      sda_f_q   <= 1'b1;
      scl_cnt_q <= 4'd0;
      sda_cnt_q <= 4'd0;
    end else begin
      scl_f_q   <= scl_f_d;
      sda_f_q   <= sda_f_d;
      scl_cnt_q <= scl_cnt_d;
      sda_cnt_q <= sda_cnt_d;
    end
  end

  assign scl_lvl = scl_f_q;
  assign sda_lvl = sda_f_q;
`else
  assign scl_lvl = scl_s2_q;
  assign sda_lvl = sda_s2_q;
`endif

  // -------------------------------------------------------------------------
  // Edge and bus-condition detection against the previous sample
  // -------------------------------------------------------------------------
  logic scl_prev_q, sda_prev_q;

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_lvl;
      sda_prev_q <= sda_lvl;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;

  // SCL must be high in both samples. If both lines move in the same sample,
  // the SCL edge is processed rather than a START/STOP.
  assign scl_rise  =  scl_lvl & ~scl_prev_q;
  assign scl_fall  = ~scl_lvl &  scl_prev_q;
  assign start_det =  scl_lvl &  scl_prev_q &  sda_prev_q & ~sda_lvl;
  assign stop_det  =  scl_lvl &  scl_prev_q & ~sda_prev_q &  sda_lvl;

  // -------------------------------------------------------------------------
  // Protocol FSM
  // -------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] data_q, data_d;
  logic       sda_oe_q, sda_oe_d;
  logic       dv_q, dv_d;
  logic       busy_q, busy_d;
  logic [7:0] byte_in;

  // Byte as it stands once the current SDA sample is shifted in
  assign byte_in = {shreg_q[6:0], sda_lvl};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    sda_oe_d  = sda_oe_q;
    dv_d      = 1'b0;
    busy_d    = busy_q;

    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;

        ST_ADDR, ST_DATA: begin
          if (scl_rise) begin
            shreg_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (state_q == ST_ADDR) begin
                if (byte_in[7:1] == ADDR && !byte_in[0]) state_d = ST_ADDR_ACK;
                else                                     state_d = ST_IGNORE;
              end else if (Ready) begin
                data_d  = byte_in;
                dv_d    = 1'b1;
                state_d = ST_DATA_ACK;
              end else begin
                state_d = ST_IGNORE;
              end
            end
          end
        end

        // The first SCL fall after the 8th rise starts driving the ACK. The
        // following fall, which ends the 9th high phase, releases it. Either
        // way SDA_oe only moves while SCL is low.
        ST_ADDR_ACK, ST_DATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = ST_DATA;
              if (state_q == ST_ADDR_ACK) busy_d = 1'b1;
            end
          end
        end

        ST_IGNORE: sda_oe_d = 1'b0;

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 4'd0;
      shreg_q   <= 8'h00;
      data_q    <= 8'h00;
      sda_oe_q  <= 1'b0;
      dv_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      sda_oe_q  <= sda_oe_d;
      dv_q      <= dv_d;
      busy_q    <= busy_d;
    end
  end

  assign SDA_oe    = sda_oe_q;
  assign Data      = data_q;
  assign DataValid = dv_q;
  assign Busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// ---------------------------------------------------------------------------
// tb_i2c_target_rx
//   Directed bench for i2c_target_rx. A bus controller model drives SCL at
//   Clock/16 and bit-bangs SDA. The SDA line is the wired-AND of the
//   controller and the DUT's open-drain pull-down. Received bytes are
//   collected by a monitor and compared against an expected queue.
// ---------------------------------------------------------------------------
module tb_i2c_target_rx;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_IGNORE = 3'd5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       ready = 1'b1;
  logic       sda_oe;
  logic [7:0] data;
  logic       data_valid;
  logic       busy;
  logic [2:0] state_dbg;
  logic       sda_bus;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_target_rx #(.ADDR(7'h42), .FILT_CYCLES(3)) dut (
    .Clock     (clk),
    .Reset_n   (rst_n),
    .SCL_in    (scl_m),
    .SDA_in    (sda_bus),
    .SDA_oe    (sda_oe),
    .Ready     (ready),
    .Data      (data),
    .DataValid (data_valid),
    .Busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic       oe_seen  = 1'b0;
  logic       saw_addr = 1'b0;

  always @(negedge clk) begin
    if (data_valid) got_q.push_back(data);
    if (sda_oe) oe_seen = 1'b1;
    if (state_dbg == S_ADDR) saw_addr = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compare everything collected so far against the expected queue.
  task automatic check_bytes(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({tag, "_byte"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    exp_q.delete();
    got_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; cyc(4);
    scl_m = 1'b1; cyc(8);
    sda_m = 1'b0; cyc(8);
    scl_m = 1'b0; cyc(4);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; cyc(4);
    scl_m = 1'b1; cyc(8);
    sda_m = 1'b1; cyc(8);
  endtask

  // Send bits first..last (index 0 = MSB) of b.
  task automatic send_bits(input logic [7:0] b, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      sda_m = b[7-i]; cyc(4);
      scl_m = 1'b1;   cyc(8);
      scl_m = 1'b0;   cyc(4);
    end
  endtask

  // Ninth clock: controller releases SDA; the target's pull-down is sampled
  // in the middle of the high phase.
  task automatic ack_slot(output logic ack);
    sda_m = 1'b1; cyc(4);
    scl_m = 1'b1; cyc(4);
    ack = sda_oe;
    cyc(4);
    scl_m = 1'b0; cyc(4);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 0, 7);
    ack_slot(ack);
  endtask

  // ---------------- stimulus ----------------
  logic ack;

  initial begin
    cyc(3);
    check("rst_oe",    32'(sda_oe),     32'd0);
    check("rst_dv",    32'(data_valid), 32'd0);
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_data",  32'(data),       32'h00);
    check("rst_state", 32'(state_dbg),  32'(S_IDLE));
    rst_n = 1'b1;
    cyc(4);

    // 1: address write, two data bytes, STOP
    got_q.delete();
    i2c_start();
    send_byte(8'h84, ack); check("t1_addr_ack", 32'(ack), 32'd1);
    send_byte(8'hA5, ack); check("t1_d0_ack",   32'(ack), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    send_byte(8'h3C, ack); check("t1_d1_ack",   32'(ack), 32'd1);
    check("t1_release", 32'(sda_oe), 32'd0);
    i2c_stop();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    check_bytes("t1");
    check("t1_busy_stop", 32'(busy), 32'd0);
    cyc(8);

    // 2: foreign address
    oe_seen = 1'b0;
    i2c_start();
    send_byte(8'h86, ack); check("t2_addr_nack", 32'(ack), 32'd0);
    send_byte(8'hFF, ack);
    i2c_stop();
    check("t2_oe_seen", 32'(oe_seen), 32'd0);
    check("t2_busy",    32'(busy),    32'd0);
    check_bytes("t2");
    cyc(8);

    // 3: read request, then a fresh START is accepted
    i2c_start();
    send_byte(8'h85, ack); check("t3_read_nack", 32'(ack),       32'd0);
    check("t3_ignore", 32'(state_dbg), 32'(S_IGNORE));
    i2c_start();
    send_byte(8'h84, ack); check("t3_restart_ack", 32'(ack), 32'd1);
    i2c_stop();
    check_bytes("t3");
    cyc(8);

    // 4: sink not ready at the 8th bit
    i2c_start();
    send_byte(8'h84, ack); check("t4_addr_ack", 32'(ack), 32'd1);
    ready = 1'b0;
    send_byte(8'h11, ack); check("t4_data_nack", 32'(ack), 32'd0);
    ready = 1'b1;
    check("t4_data_kept", 32'(data),      32'h3C);
    check("t4_ignore",    32'(state_dbg), 32'(S_IGNORE));
    check_bytes("t4");
    i2c_start();
    send_byte(8'h84, ack); check("t4_rs_ack", 32'(ack), 32'd1);
    check("t4_rs_busy", 32'(busy), 32'd1);
    i2c_stop();
    cyc(8);

    // 5: reset pulse during bit 4 of a data byte
    i2c_start();
    send_byte(8'h84, ack); check("t5_addr_ack", 32'(ack), 32'd1);
    send_bits(8'h5A, 0, 2);
    sda_m = 1'b1; cyc(2);
    rst_n = 1'b0; cyc(1);
    rst_n = 1'b1;
    check("t5_oe",    32'(sda_oe),    32'd0);
    check("t5_state", 32'(state_dbg), 32'(S_IDLE));
    check("t5_busy",  32'(busy),      32'd0);
    cyc(1);
    scl_m = 1'b1; cyc(8);
    scl_m = 1'b0; cyc(4);
    send_bits(8'h5A, 4, 7);
    ack_slot(ack);
    check("t5_no_ack",    32'(ack),       32'd0);
    check("t5_still_idle", 32'(state_dbg), 32'(S_IDLE));
    check_bytes("t5");
    i2c_stop();
    cyc(8);

    // 6: 2-cycle SDA low glitch while SCL is high
    saw_addr = 1'b0;
    sda_m = 1'b0; cyc(2);
    sda_m = 1'b1; cyc(16);
`ifdef I2C_GLITCH_FILTER_EN
    check("t6_glitch_start", 32'(saw_addr), 32'd0);
`else
    check("t6_glitch_start", 32'(saw_addr), 32'd1);
`endif
    check("t6_idle", 32'(state_dbg), 32'(S_IDLE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
